// File: rtl/GLOBAL_PARAM.sv
// GLOBAL_PARAM: datapath widths shared across the PE array and its helpers.
package GLOBAL_PARAM;
  localparam int DATA_W = 16;
  localparam int BATCH = 4;
  localparam int RES_W = 32;
  function automatic int bw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pe_result_drain_pkg.sv
// pe_result_drain_pkg: drain controller state encoding and control widths.
package pe_result_drain_pkg;
  localparam int SHIFT_W = 5;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/pe_result_drain_if.sv
// pe_result_drain_if: drain control, accumulation-buffer read port and quantised output stream.
interface pe_result_drain_if #(parameter int BUF_DEPTH = 256) ();
  import GLOBAL_PARAM::*;
  import pe_result_drain_pkg::*;
  localparam int ADDR_W = bw(BUF_DEPTH);
  logic start;
  logic [ADDR_W-1:0] len;
  logic [SHIFT_W-1:0] shift;
  logic relu_en;
  logic done;
  logic [ADDR_W-1:0] abuf_rd_addr;
  logic [BATCH*RES_W-1:0] abuf_rd_data;
  logic [DATA_W*BATCH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  modport master (
    input start, len, shift, relu_en, abuf_rd_data, out_ready,
    output done, abuf_rd_addr, out_data, out_valid, out_last
  );
  modport slave (
    output start, len, shift, relu_en, abuf_rd_data, out_ready,
    input done, abuf_rd_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/res_fifo.sv
// res_fifo: first-word fall-through skid FIFO; dout reads zero while empty.
module res_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_pop;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign dout = valid ? mem[rd] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr == PW'(DEPTH-1) ? '0 : wr + PW'(1);
      if (do_pop) rd <= rd == PW'(DEPTH-1) ? '0 : rd + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
endmodule

// File: rtl/pe_result_drain.sv
// pe_result_drain: streams accumulation-buffer words through per-lane round/shift/
// saturate/ReLU quantisation into a credit-limited skid FIFO.
module pe_result_drain
  import GLOBAL_PARAM::*;
  import pe_result_drain_pkg::*;
#(
  parameter int BUF_DEPTH = 256,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  pe_result_drain_if.master bus
);
  localparam int AW = bw(BUF_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int QW = DATA_W*BATCH;
  localparam logic signed [RES_W:0] MAXV = (RES_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [RES_W:0] MINV = ~MAXV;
  state_t state, nxt;
  logic [AW-1:0] addr, len_q;
  logic [SHIFT_W-1:0] shift_q;
  logic relu_q;
  logic [RD_LAT-1:0] rv, rl;
  logic q_vld, q_last;
  logic [QW-1:0] q_data, qn;
  logic [CW-1:0] infl, cnt;
  logic credit, issue, last_issue, fire;
  logic [QW:0] fifo_out;
  // Credits cover the FIFO plus every read still in the RAM/quantiser pipe.
  assign credit = ({1'b0, cnt} + {1'b0, infl}) < (CW+1)'(FIFO_DEPTH);
  assign issue = state == RUN && credit;
  assign last_issue = issue && addr == len_q;
  assign fire = bus.out_valid && bus.out_ready;
  assign bus.done = state == DRAIN && fire && bus.out_last;
  assign bus.abuf_rd_addr = addr;
  assign {bus.out_last, bus.out_data} = fifo_out;
  always_comb begin
    nxt = state;
    nxt = (state == IDLE && bus.start) ? RUN : last_issue ? DRAIN : bus.done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      len_q <= '0;
      shift_q <= '0;
      relu_q <= 1'b0;
      rv <= '0;
      rl <= '0;
      q_vld <= 1'b0;
      q_last <= 1'b0;
      q_data <= '0;
      infl <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        len_q <= bus.len;
        shift_q <= bus.shift;
        relu_q <= bus.relu_en;
      end
      if (issue) addr <= last_issue ? '0 : addr + AW'(1);
      rv[0] <= issue;
      rl[0] <= last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        rv[i] <= rv[i-1];
        rl[i] <= rl[i-1];
      end
      q_vld <= rv[RD_LAT-1];
      q_last <= rl[RD_LAT-1];
      if (rv[RD_LAT-1]) q_data <= qn;
      infl <= infl + CW'(issue) - CW'(q_vld);
    end
  // Rounding is done one bit wider than the input so +2^(shift-1) cannot wrap.
  for (genvar g = 0; g < BATCH; g++) begin : g_lane
    logic signed [RES_W:0] ext, rnd, shd;
    logic signed [DATA_W-1:0] sat;
    assign ext = $signed({bus.abuf_rd_data[g*RES_W+RES_W-1], bus.abuf_rd_data[g*RES_W +: RES_W]});
    assign rnd = shift_q == '0 ? ext : ext + $signed((RES_W+1)'(1) << (shift_q - SHIFT_W'(1)));
    assign shd = rnd >>> shift_q;
    assign sat = shd > MAXV ? MAXV[DATA_W-1:0] : shd < MINV ? MINV[DATA_W-1:0] : shd[DATA_W-1:0];
    assign qn[g*DATA_W +: DATA_W] = relu_q && sat[DATA_W-1] ? '0 : sat;
  end
  res_fifo #(.W(QW+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(q_vld),
    .din({q_last, q_data}),
    .pop(bus.out_ready),
    .dout(fifo_out),
    .valid(bus.out_valid),
    .count(cnt)
  );
endmodule

// File: tb/tb_pe_result_drain.sv
// tb_pe_result_drain: directed, table-driven checks of quantisation, flow control
// and drain boundaries for pe_result_drain.
module tb_pe_result_drain;
  localparam int BUF_DEPTH = 256;
  localparam int RD_LAT = 1;
  localparam int FIFO_DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pe_result_drain_if #(.BUF_DEPTH(BUF_DEPTH)) bus ();
  pe_result_drain #(.BUF_DEPTH(BUF_DEPTH), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [127:0] mem [BUF_DEPTH];
  logic rdy_fix = 1'b1;
  logic rnd_mode = 1'b0;
  always @(posedge clk) bus.abuf_rd_data <= mem[bus.abuf_rd_addr];
  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : rdy_fix;
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [63:0] got_data[$];
  logic got_last[$];
  logic got_done[$];
  int got_cyc[$];
  int done_cnt = 0;
  logic addr_hit [BUF_DEPTH] = '{default: 1'b0};
  always @(negedge clk)
    if (rst) begin
      addr_hit[bus.abuf_rd_addr] = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        got_done.push_back(bus.done);
        got_cyc.push_back(cyc);
      end
      if (bus.done) done_cnt++;
    end
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_drain(input int l, input int sh, input logic r);
    bus.start = 1'b1;
    bus.len = 8'(l);
    bus.shift = 5'(sh);
    bus.relu_en = r;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_beats(input int n, input int budget, input string nm);
    int k = 0;
    while (got_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got_data.size() < n) chk({nm, " timeout beats"}, 64'(got_data.size()), 64'(n));
  endtask
  function automatic logic [127:0] pat(input int i);
    return {32'(7), 32'(3*i), 32'(-i), 32'(i)};
  endfunction
  function automatic logic [63:0] exp_pat(input int i);
    return {16'(7), 16'(3*i), 16'(-i), 16'(i)};
  endfunction
  typedef struct {
    logic [127:0] word;
    int sh;
    logic relu;
    logic [63:0] exp;
    string nm;
  } vec_t;
  vec_t vecs [6];
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int b0, d0, st, errs;
    vecs[0] = '{{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FFFF, 32'd1}, 0, 1'b0,
                {16'hFF9C, 16'h0064, 16'hFFFF, 16'h0001}, "passthru"};
    vecs[1] = '{{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFE8, 32'd24}, 4, 1'b0,
                {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0002}, "round_sat"};
    vecs[2] = '{{32'd40000, 32'hFFFF_63C0, 32'd5, 32'hFFFF_FFFB}, 0, 1'b1,
                {16'h7FFF, 16'h0000, 16'h0005, 16'h0000}, "relu"};
    vecs[3] = '{{32'h0001_8000, 32'hFFFF_FFF7, 32'hFFFF_FFF8, 32'd7}, 1, 1'b0,
                {16'h7FFF, 16'hFFFC, 16'hFFFC, 16'h0004}, "shift1"};
    vecs[4] = '{{32'hC000_0000, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF}, 31, 1'b0,
                {16'h0000, 16'h0001, 16'hFFFF, 16'h0001}, "shift31_nowrap"};
    vecs[5] = '{{32'h0010_0000, 32'hFFF0_0000, 32'd8, 32'hFFFF_FFFF}, 2, 1'b1,
                {16'h7FFF, 16'h0000, 16'h0002, 16'h0000}, "relu_shift2"};
    for (int i = 0; i < BUF_DEPTH; i++) mem[i] = '0;
    bus.start = 1'b0;
    bus.len = '0;
    bus.shift = '0;
    bus.relu_en = 1'b0;
    repeat (3) tick();
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_last", 64'(bus.out_last), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset addr", 64'(bus.abuf_rd_addr), 64'd0);
    chk("reset out_data", bus.out_data, 64'd0);
    rst = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      mem[0] = vecs[k].word;
      b0 = got_data.size();
      start_drain(0, vecs[k].sh, vecs[k].relu);
      wait_beats(b0 + 1, 20, vecs[k].nm);
      repeat (3) tick();
      chk({vecs[k].nm, " data"}, got_data[b0], vecs[k].exp);
      chk({vecs[k].nm, " last"}, 64'(got_last[b0]), 64'd1);
      chk({vecs[k].nm, " done"}, 64'(got_done[b0]), 64'd1);
      chk({vecs[k].nm, " beats"}, 64'(got_data.size() - b0), 64'd1);
    end
    for (int i = 0; i < 4; i++) mem[i] = vecs[0].word;
    b0 = got_data.size();
    d0 = done_cnt;
    st = cyc;
    start_drain(3, 0, 1'b0);
    wait_beats(b0 + 4, 30, "basic");
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic beat%0d data", i), got_data[b0+i], vecs[0].exp);
      chk($sformatf("basic beat%0d last", i), 64'(got_last[b0+i]), 64'(i == 3));
    end
    chk("basic done with last", 64'(got_done[b0+3]), 64'd1);
    chk("basic done pulses", 64'(done_cnt - d0), 64'd1);
    chk("basic throughput", 64'(got_cyc[b0+3] - got_cyc[b0]), 64'd3);
    chk("basic first-beat latency", 64'(got_cyc[b0] - st >= RD_LAT + 3), 64'd1);
    chk("idle addr", 64'(bus.abuf_rd_addr), 64'd0);
    for (int i = 0; i < BUF_DEPTH; i++) mem[i] = pat(i);
    rdy_fix = 1'b0;
    b0 = got_data.size();
    start_drain(15, 0, 1'b0);
    repeat (20) tick();
    chk("credit stall addr", 64'(bus.abuf_rd_addr), 64'(FIFO_DEPTH));
    chk("stall out_valid", 64'(bus.out_valid), 64'd1);
    chk("stall out_data", bus.out_data, exp_pat(0));
    chk("stall no beats", 64'(got_data.size() - b0), 64'd0);
    rnd_mode = 1'b1;
    wait_beats(b0 + 16, 400, "backpressure");
    rnd_mode = 1'b0;
    rdy_fix = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bp beat%0d data", i), got_data[b0+i], exp_pat(i));
      chk($sformatf("bp beat%0d last", i), 64'(got_last[b0+i]), 64'(i == 15));
    end
    chk("bp beats", 64'(got_data.size() - b0), 64'd16);
    b0 = got_data.size();
    d0 = done_cnt;
    start_drain(7, 0, 1'b0);
    repeat (3) tick();
    start_drain(0, 4, 1'b1);
    wait_beats(b0 + 8, 60, "mid start");
    repeat (5) tick();
    chk("mid start beats", 64'(got_data.size() - b0), 64'd8);
    chk("mid start beat3 data", got_data[b0+3], exp_pat(3));
    chk("mid start beat7 data", got_data[b0+7], exp_pat(7));
    chk("mid start last", 64'(got_last[b0+7]), 64'd1);
    chk("mid start done pulses", 64'(done_cnt - d0), 64'd1);
    b0 = got_data.size();
    start_drain(255, 0, 1'b0);
    wait_beats(b0 + 256, 600, "full");
    repeat (5) tick();
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (got_data[b0+i] !== exp_pat(i) || got_last[b0+i] !== (i == 255)) errs++;
    chk("full order errors", 64'(errs), 64'd0);
    chk("full beats", 64'(got_data.size() - b0), 64'd256);
    chk("full last data", got_data[b0+255], exp_pat(255));
    chk("full throughput", 64'(got_cyc[b0+255] - got_cyc[b0]), 64'd255);
    chk("full addr 255 seen", 64'(addr_hit[255]), 64'd1);
    chk("full idle addr", 64'(bus.abuf_rd_addr), 64'd0);
    b0 = got_data.size();
    d0 = done_cnt;
    start_drain(15, 0, 1'b0);
    wait_beats(b0 + 5, 40, "reset wait");
    rst = 1'b0;
    #1;
    chk("mid reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid reset out_last", 64'(bus.out_last), 64'd0);
    chk("mid reset addr", 64'(bus.abuf_rd_addr), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("mid reset no stale beats", 64'(got_data.size() - b0), 64'd5);
    chk("mid reset no done", 64'(done_cnt - d0), 64'd0);
    b0 = got_data.size();
    d0 = done_cnt;
    start_drain(1, 0, 1'b0);
    wait_beats(b0 + 2, 20, "post reset");
    repeat (5) tick();
    chk("post reset beats", 64'(got_data.size() - b0), 64'd2);
    chk("post reset beat0 data", got_data[b0], exp_pat(0));
    chk("post reset beat1 data", got_data[b0+1], exp_pat(1));
    chk("post reset last", 64'(got_last[b0+1]), 64'd1);
    chk("post reset done pulses", 64'(done_cnt - d0), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pe_result_drain.md
PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

Interface
REQ-001 Parameter BUF_DEPTH, default 256: accumulation-buffer depth in words.
REQ-002 Parameter RD_LAT, default 1: cycles from abuf_rd_addr to valid abuf_rd_data.
REQ-003 Parameter FIFO_DEPTH, default 4: output skid FIFO depth in beats; SHALL be at least RD_LAT+2.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a drain; honoured only in IDLE.
REQ-007 len  in  bw(BUF_DEPTH)  word count minus 1; sampled with start.
REQ-008 shift  in  5  arithmetic right-shift amount; sampled with start.
REQ-009 relu_en  in  1  clamp negative results to 0; sampled with start.
REQ-010 done  out  1  one-cycle pulse after the last beat is accepted.
REQ-011 abuf_rd_addr  out  bw(BUF_DEPTH)  read address to the PE accumulation buffer.
REQ-012 abuf_rd_data  in  BATCH*RES_W  read data; lane i is bits [i*RES_W +: RES_W].
REQ-013 out_data  out  DATA_W*BATCH  quantised beat; lane i is bits [i*DATA_W +: DATA_W].
REQ-014 out_valid  out  1  beat available.
REQ-015 out_ready  in  1  consumer accepts; a beat transfers when out_valid and out_ready are both high.
REQ-016 out_last  out  1  high with the final beat of a drain.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start.
- RUN -> DRAIN in the cycle address len is issued.
- DRAIN -> IDLE when the beat carrying out_last transfers; done pulses in that same cycle.
REQ-018 In RUN, addresses are issued 0,1,...,len in order, at most one per cycle; no address is repeated or skipped.
REQ-019 Credit rule: an address is issued only when (FIFO occupancy + reads in flight) < FIFO_DEPTH; the FIFO therefore never overflows and no read is discarded.
REQ-020 Pipeline per read: RD_LAT cycles RAM, then one quantisation register, then FIFO write. out_valid may therefore rise no earlier than RD_LAT+2 cycles after the first address issue.
REQ-021 Quantisation is per lane, with input treated as signed RES_W:
- if shift>0, add 2^(shift-1) (round half-up), then arithmetic right shift by shift;
- saturate to signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1];
- if relu_en, force negative results to 0.
REQ-022 Rounding addition SHALL be computed at RES_W+1 bits so it never wraps.
REQ-023 The FIFO is first-word fall-through. out_data/out_last are stable while out_valid=1 and out_ready=0.
REQ-024 With out_ready held high and no stalls, the block sustains one beat per cycle.
REQ-025 len=0 drains exactly one word. len=BUF_DEPTH-1 drains all words; the address counter SHALL not wrap past len.
REQ-026 start asserted outside IDLE is ignored and does not alter len, shift, or relu_en.
REQ-027 Simultaneous FIFO push and pop at full or empty leaves occupancy unchanged and loses no data.
REQ-028 While idle, abuf_rd_addr holds 0.

Reset
REQ-029 Reset puts the block in IDLE and clears the FIFO, in-flight count, and address counter; out_valid=0, out_last=0, done=0, abuf_rd_addr=0, out_data=0.
REQ-030 Reset asserted mid-drain aborts the drain immediately. No done pulse is produced, and no beat from the aborted drain appears after reset is released.

Structure
REQ-031 DATA_W, BATCH, RES_W and the bw() function come from the shared GLOBAL_PARAM package; no new package types are required.
REQ-032 The skid FIFO SHALL be a separate sub-module named res_fifo, parameterised by width and depth. The quantiser stays inline, generated per lane.

Verification (bench: BATCH=4, RES_W=32, DATA_W=16, RD_LAT=1)
REQ-033 Basic drain: len=3, shift=0, relu_en=0, buffer words 0..3 holding lane values {1,-1,100,-100}, out_ready=1 -> 4 beats with identical values, out_last on beat 4, done in the same cycle, throughput 1 beat/cycle.
REQ-034 Rounding and saturation: shift=4, inputs {24, -24, 0x7FFF_FFFF, 0x8000_0000} -> outputs {2, -1, 32767, -32768}.
REQ-035 ReLU: relu_en=1, shift=0, inputs {-5, 5, -40000, 40000} -> outputs {0, 5, 0, 32767}.
REQ-036 Backpressure: len=15, out_ready toggled randomly at 30% high -> all 16 beats arrive in address order with none lost or duplicated; addresses stall when credits are exhausted.
REQ-037 Boundaries: len=0 gives one beat with out_last; len=255 gives 256 beats with last address 255. A start pulse mid-drain has no effect. Reset asserted on beat 5 of 16 gives out_valid=0 immediately, and a subsequent start with len=1 yields exactly 2 beats.
